// File: rtl/alu_or_sched_if.sv
// Request/response bundle between the requesters and the shared OR-reduce scheduler.
// The master side drives requests and rsp_ready. The slave side is the scheduler.
interface alu_or_sched_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_din;
  logic [NREQ*3-1:0]  req_funct;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_res;
  logic               rsp_err;

  modport master (
    output req_valid, req_din, req_funct, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );

  modport slave (
    input  req_valid, req_din, req_funct, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );
endinterface

// File: rtl/alu_or_sched.sv
// Round-robin scheduler that shares one segmented OR-reduce datapath among NREQ requesters.
// Define ALU_OR_STATS_EN to add the saturating stat_ops/stat_errs response counters.
module alu_or_sched #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_or_sched_if.slave        bus,
  output logic                 busy
`ifdef ALU_OR_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_errs
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     op_din_q, op_din_d;
  logic [2:0]      op_funct_q, op_funct_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [31:0]     rsp_res_q, rsp_res_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  gnt_nxt;
  logic [IDW-1:0]  cand;
  logic [31:0]     cap_din;
  logic [2:0]      cap_funct;
  logic [NREQ-1:0] req_ready_c;
  logic            rsp_valid_c;

  // Segmented OR-reduce: each segment's OR lands on the segment LSB, other bits stay 0.
  function automatic logic [31:0] seg_or(input logic [31:0] din, input logic [2:0] funct);
    logic [31:0] r;
    r = '0;
    case (funct)
      3'd0: r = din;
      3'd1: for (int i = 0; i < 16; i++) r[i*2]  = |din[i*2 +: 2];
      3'd2: for (int i = 0; i < 8; i++)  r[i*4]  = |din[i*4 +: 4];
      3'd3: for (int i = 0; i < 4; i++)  r[i*8]  = |din[i*8 +: 8];
      3'd4: for (int i = 0; i < 2; i++)  r[i*16] = |din[i*16 +: 16];
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_nxt = IDW'((int'(gnt_idx) + 1) % NREQ);
  end

  always_comb begin
    cap_din   = '0;
    cap_funct = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        cap_din   = bus.req_din[k*32 +: 32];
        cap_funct = bus.req_funct[k*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_din_d    = op_din_q;
    op_funct_d  = op_funct_q;
    op_id_d     = op_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    req_ready_c = '0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          op_din_d             = cap_din;
          op_funct_d           = cap_funct;
          op_id_d              = gnt_idx;
          rr_ptr_d             = gnt_nxt;
          state_d              = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d = seg_or(op_din_q, op_funct_q);
        rsp_err_d = (op_funct_q > 3'd4);
        rsp_id_d  = op_id_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_din_q   <= '0;
      op_funct_q <= '0;
      op_id_q    <= '0;
      rsp_res_q  <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_din_q   <= op_din_d;
      op_funct_q <= op_funct_d;
      op_id_q    <= op_id_d;
      rsp_res_q  <= rsp_res_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Keep the combinational grant quiet while reset is held so every output reads 0.
  assign bus.req_ready = req_ready_c & {NREQ{~rst}};
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);

`ifdef ALU_OR_STATS_EN
  logic [15:0] stat_ops_q, stat_errs_q;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_c && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (rsp_err_q && stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_or_sched.sv
// Directed bench for alu_or_sched: single ops, round-robin order, back-pressure and reset abort.
module tb_alu_or_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef ALU_OR_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  alu_or_sched_if #(.NREQ(NREQ)) bus_if ();

  alu_or_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy)
`ifdef ALU_OR_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 3 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_reqs();
    bus_if.req_valid = '0;
    bus_if.req_din   = '0;
    bus_if.req_funct = '0;
  endtask

  task automatic set_req(input int r, input logic [31:0] din, input logic [2:0] f);
    bus_if.req_valid[r]        = 1'b1;
    bus_if.req_din[r*32 +: 32] = din;
    bus_if.req_funct[r*3 +: 3] = f;
  endtask

  task automatic do_single(input string tag, input int r, input logic [31:0] din,
                           input logic [2:0] f, input logic [31:0] eres, input logic eerr);
    clear_reqs();
    set_req(r, din, f);
    bus_if.rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready_T"}, 32'(bus_if.req_ready), 32'(1 << r));
    tick();
    bus_if.req_valid = '0;
    #1;
    chk({tag, "_busy_T1"}, 32'(busy), 32'd1);
    chk({tag, "_vld_T1"}, 32'(bus_if.rsp_valid), 32'd0);
    tick();
    chk({tag, "_vld_T2"}, 32'(bus_if.rsp_valid), 32'd1);
    chk({tag, "_res"}, bus_if.rsp_res, eres);
    chk({tag, "_id"}, 32'(bus_if.rsp_id), 32'(r));
    chk({tag, "_err"}, 32'(bus_if.rsp_err), 32'(eerr));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] rr_din [4];
  logic [2:0]  rr_fn  [4];
  logic [31:0] rr_exp [4];
  int          rr_order [5];

  initial begin
    rst = 1'b1;
    clear_reqs();
    bus_if.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_res", bus_if.rsp_res, 32'd0);
    chk("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single-requester operations
    do_single("t1", 0, 32'h0000_0003, 3'd1, 32'h0000_0001, 1'b0);
    do_single("t2a", 2, 32'h0001_0000, 3'd4, 32'h0001_0000, 1'b0);
    do_single("t3", 1, 32'h1234_5678, 3'd5, 32'hDEAD_BEEF, 1'b1);
`ifdef ALU_OR_STATS_EN
    chk("stat_ops_3", 32'(stat_ops), 32'd3);
    chk("stat_errs_1", 32'(stat_errs), 32'd1);
`endif
    do_single("t2b", 2, 32'h8000_0000, 3'd3, 32'h0100_0000, 1'b0);
    do_single("f2", 0, 32'h0000_F00F, 3'd2, 32'h0000_1001, 1'b0);
    do_single("f0", 1, 32'hCAFE_0123, 3'd0, 32'hCAFE_0123, 1'b0);
    do_single("f7", 3, 32'h0000_0000, 3'd7, 32'hDEAD_BEEF, 1'b1);

    // Back-pressure: rr_ptr is 0 here, so with 2 and 3 pending requester 2 wins.
    clear_reqs();
    set_req(2, 32'hA5A5_A5A5, 3'd0);
    set_req(3, 32'h0000_0001, 3'd0);
    bus_if.rsp_ready = 1'b0;
    #1;
    chk("t5_ready", 32'(bus_if.req_ready), 32'b0100);
    tick();
    bus_if.req_valid[2] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_vld", 32'(bus_if.rsp_valid), 32'd1);
      chk("t5_res", bus_if.rsp_res, 32'hA5A5_A5A5);
      chk("t5_id", 32'(bus_if.rsp_id), 32'd2);
      chk("t5_err", 32'(bus_if.rsp_err), 32'd0);
      chk("t5_noready", 32'(bus_if.req_ready), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      tick();
    end
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("t5_vld_hs", 32'(bus_if.rsp_valid), 32'd1);
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_vld_off", 32'(bus_if.rsp_valid), 32'd0);
    chk("t5_next_ready", 32'(bus_if.req_ready), 32'b1000);
    // Requester 3 withdraws before the edge: nothing is captured.
    bus_if.req_valid = '0;
    #1;
    chk("drop_ready", 32'(bus_if.req_ready), 32'd0);
    tick();
    chk("drop_busy", 32'(busy), 32'd0);

    // Reset during EXEC drops the transaction.
    clear_reqs();
    set_req(0, 32'h0000_0003, 3'd1);
    #1;
    tick();
    bus_if.req_valid = '0;
    #1;
    chk("t6_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_vld", 32'(bus_if.rsp_valid), 32'd0);
    chk("t6_res", bus_if.rsp_res, 32'd0);
    chk("t6_id", 32'(bus_if.rsp_id), 32'd0);
    chk("t6_err", 32'(bus_if.rsp_err), 32'd0);
    chk("t6_ready", 32'(bus_if.req_ready), 32'd0);
`ifdef ALU_OR_STATS_EN
    chk("t6_stat_ops", 32'(stat_ops), 32'd0);
    chk("t6_stat_errs", 32'(stat_errs), 32'd0);
`endif
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    end

    // All four requesters held: grants 0,1,2,3,0 every 3 cycles.
    rr_din[0] = 32'h1111_0000; rr_fn[0] = 3'd0; rr_exp[0] = 32'h1111_0000;
    rr_din[1] = 32'h0000_F00F; rr_fn[1] = 3'd2; rr_exp[1] = 32'h0000_1001;
    rr_din[2] = 32'h0300_0000; rr_fn[2] = 3'd1; rr_exp[2] = 32'h0100_0000;
    rr_din[3] = 32'h0080_0001; rr_fn[3] = 3'd3; rr_exp[3] = 32'h0001_0001;
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;
    clear_reqs();
    for (int r = 0; r < 4; r++) set_req(r, rr_din[r], rr_fn[r]);
    bus_if.rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("t4_grant", 32'(bus_if.req_ready), 32'(1 << rr_order[n]));
      tick();
      chk("t4_exec_ready", 32'(bus_if.req_ready), 32'd0);
      tick();
      chk("t4_vld", 32'(bus_if.rsp_valid), 32'd1);
      chk("t4_id", 32'(bus_if.rsp_id), 32'(rr_order[n]));
      chk("t4_res", bus_if.rsp_res, rr_exp[rr_order[n]]);
      chk("t4_resp_ready", 32'(bus_if.req_ready), 32'd0);
      tick();
    end
    clear_reqs();
    tick();
    tick();
    chk("end_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
